// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin grant held until the tail flit,
// crossbar select, and credit-gated flit transfer toward the downstream buffer.
module output_port_allocator #(
    parameter int N_IN     = 5,
    parameter int CRED_MAX = 4,
    parameter int CW       = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] req,
    input  logic [N_IN-1:0] tail,
    input  logic            credit_in,
    output logic [N_IN-1:0] gnt,
    output logic [2:0]      sel,
    output logic            fire,
    output logic            busy,
    output logic [CW-1:0]   credits,
    output logic            cred_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [2:0]      ptr, ptr_nxt;
    logic [2:0]      pick, idx;
    logic            found;
    logic [N_IN-1:0] gnt_nxt;
    logic [2:0]      sel_nxt;
    logic            busy_nxt;
    logic            cred_full;

    // Saturating credit update; fire and credit_in together cancel out.
    function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] c,
                                                  input logic dec,
                                                  input logic inc);
        logic [CW-1:0] r;
        r = c;
        if (dec && !inc)
            r = c - CW'(1);
        else if (inc && !dec && c != CW'(CRED_MAX))
            r = c + CW'(1);
        return r;
    endfunction

    // First requester at or after ptr, wrapping modulo N_IN.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = 3'((int'(ptr) + k) % N_IN);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign fire      = (state == LOCKED) && req[sel] && (credits != '0);
    assign cred_full = (credits == CW'(CRED_MAX));

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        busy_nxt  = busy;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = N_IN'(1) << pick;
                    sel_nxt   = pick;
                    busy_nxt  = 1'b1;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (fire && tail[sel]) begin
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                    ptr_nxt   = (sel == 3'(N_IN - 1)) ? 3'd0 : sel + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            credits  <= CW'(CRED_MAX);
            cred_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            busy     <= busy_nxt;
            ptr      <= ptr_nxt;
            credits  <= credit_next(credits, fire, credit_in);
            cred_err <= cred_err | (credit_in & ~fire & cred_full);
        end
    end

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
Per-output-port wormhole allocator for the 5-port router.
- Takes route-compute requests from the five input FIFOs (local, east, west, north, south) that target this output.
- Grants the port round-robin to one input and holds the grant until that packet's tail flit has passed.
- Drives the crossbar select for the port.
- Gates flit transfer on a credit counter that tracks free slots in the downstream input buffer.

Parameters:
- N_IN, 5, number of requesting input ports (index 0..4).
- CRED_MAX, 4, downstream buffer depth; credit counter reset value and ceiling.
- CW, 3, credit counter width; must hold CRED_MAX.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_IN  req[i]=1: input i holds a flit routed to this output.
- tail  input  N_IN  tail[i]=1: the flit at the head of input i is a packet tail; single-flit packets are head=tail.
- credit_in  input  1  one-cycle pulse; downstream freed one buffer slot.
- gnt  output  N_IN  one-hot grant, registered; all-zero when idle.
- sel  output  3  binary index of the granted input, registered; crossbar select.
- fire  output  1  combinational; a flit moves from input sel to this output in this cycle; also the read strobe for the owning FIFO.
- busy  output  1  registered; 1 while in LOCKED.
- credits  output  CW  current credit count.
- cred_err  output  1  sticky; credit_in was received while credits==CRED_MAX.

Behaviour:
- Reset values (rst low, asynchronous): state=IDLE, gnt=0, sel=0, busy=0, ptr=0, credits=CRED_MAX, cred_err=0. Reset mid-packet aborts the packet immediately; no fire after reset deasserts until a new grant is made.
- FSM states: IDLE and LOCKED; ptr is the round-robin priority pointer, range 0..N_IN-1.
- IDLE:
  - If req!=0, pick the first i with req[i]=1, searching ptr, ptr+1, ... with wrap modulo N_IN.
  - Next edge: gnt=one-hot(i), sel=i, busy=1, state=LOCKED.
  - Credits are not checked at arbitration time.
  - If req==0, stay in IDLE with gnt=0.
  - fire=0 always in IDLE.
- LOCKED with owner o=sel:
  - fire = req[o] & (credits!=0).
  - Other req bits are ignored. No preemption.
  - If req[o] drops mid-packet, the grant is held and fire=0.
  - If fire & tail[o]: next edge gnt=0, busy=0, state=IDLE, ptr=(o+1) mod N_IN (wrap 4->0).
  - If fire & !tail[o]: stay in LOCKED.
- Latency:
  - Grant appears the cycle after a request is seen in IDLE.
  - The earliest fire is in the same cycle the grant is visible.
  - Between packets there is one IDLE cycle after the tail flit.
  - A single-flit packet occupies 2 cycles: grant cycle with fire, then IDLE.
- Credits:
  - Each fire decrements, each credit_in increments.
  - fire and credit_in in the same cycle: count unchanged.
  - credit_in at CRED_MAX without fire: count stays CRED_MAX and cred_err is set; only reset clears it.
  - The count can never go below 0 because fire requires credits!=0.
- Priority: only ptr advances fairness. The pointer is not updated in IDLE cycles that have no grant.

Test Plan:
1. Reset, then req=5'b00001 with tail=1 on the first flit -> gnt=00001 and sel=0 one cycle later; fire=1 that cycle; credits 4->3; next cycle gnt=0 and ptr=1.
2. All five req held high, every flit a tail -> grants in order 0,1,2,3,4,0 with one IDLE cycle between grants; credit_in pulsed each cycle keeps credits at 4.
3. Input 2 sends a 3-flit packet (tail on the 3rd) while req[0]=req[4]=1 -> gnt stays 00100 across all 3 fires, then the next grant goes to 4 (ptr=3 searches 3,4); input 0 is served after that.
4. No credit_in with a 6-flit packet -> 4 fires, then credits=0 and fire=0 with gnt held; one credit_in pulse -> exactly one more fire.
5. credits=4 and credit_in pulsed -> credits stays 4 and cred_err=1 until reset; a same-cycle fire plus credit_in at credits=2 -> credits stays 2.
6. Assert rst low mid-packet (gnt=01000) -> gnt=0, sel=0, busy=0 and credits=4 immediately, without waiting for a clock; after release, arbitration restarts from ptr=0.
